// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: merges the core's I and D ports onto one req/ack bus.
// Data requests win; one transaction outstanding; read data held per port.
module rv32i_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_i_addr,
  input  logic        mem_i_rstrb,
  output logic [31:0] mem_i_rdata,
  output logic        mem_i_rbusy,
  input  logic [31:0] mem_d_addr,
  input  logic [31:0] mem_d_wdata,
  input  logic [3:0]  mem_d_wmask,
  input  logic        mem_d_wstrb,
  input  logic        mem_d_rstrb,
  output logic [31:0] mem_d_rdata,
  output logic        mem_d_rbusy,
  output logic        mem_d_wbusy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D
  } state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic        pend_i_q, pend_i_d;
  logic        pend_d_q, pend_d_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_wmask_q, d_wmask_d;
  logic        d_we_q, d_we_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic ack_i, ack_d;
  logic new_i, new_d;
  logic req_i, req_d;
  logic launch;
  logic sel_we;

  assign ack_i = bus_ack & (state_q == BUS_I);
  assign ack_d = bus_ack & (state_q == BUS_D);

  // A port's own strobe during its ack cycle is not new: pend is still set.
  assign new_i = mem_i_rstrb & ~pend_i_q;
  assign new_d = (mem_d_wstrb | mem_d_rstrb) & ~pend_d_q;

  assign req_i = (pend_i_q & ~ack_i) | new_i;
  assign req_d = (pend_d_q & ~ack_d) | new_d;

  assign launch = (state_q == IDLE) | ack_i | ack_d;
  assign sel_we = new_d ? mem_d_wstrb : d_we_q;

  assign mem_i_rbusy = (mem_i_rstrb | pend_i_q) & ~ack_i;
  assign mem_d_rbusy = ((mem_d_rstrb & ~mem_d_wstrb)
                       | (pend_d_q & ~d_we_q)) & ~ack_d;
  assign mem_d_wbusy = (mem_d_wstrb | (pend_d_q & d_we_q)) & ~ack_d;

  assign mem_i_rdata = i_rdata_q;
  assign mem_d_rdata = d_rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wmask   = bus_wmask_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    pend_i_d    = pend_i_q;
    pend_d_d    = pend_d_q;
    i_addr_d    = i_addr_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_wmask_d   = d_wmask_q;
    d_we_d      = d_we_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (new_i) begin
      pend_i_d = 1'b1;
      i_addr_d = mem_i_addr;
    end else if (ack_i) begin
      pend_i_d = 1'b0;
    end

    if (new_d) begin
      pend_d_d  = 1'b1;
      d_addr_d  = mem_d_addr;
      d_wdata_d = mem_d_wdata;
      d_wmask_d = mem_d_wmask;
      d_we_d    = mem_d_wstrb;
    end else if (ack_d) begin
      pend_d_d = 1'b0;
    end

    if (ack_i)
      i_rdata_d = bus_rdata;
    if (ack_d && !bus_we_q)
      d_rdata_d = bus_rdata;

    if (launch) begin
      if (req_d) begin
        state_d     = BUS_D;
        bus_req_d   = 1'b1;
        bus_we_d    = sel_we;
        bus_addr_d  = new_d ? mem_d_addr : d_addr_q;
        bus_wdata_d = new_d ? mem_d_wdata : d_wdata_q;
        bus_wmask_d = !sel_we ? 4'hF
                    : (new_d ? mem_d_wmask : d_wmask_q);
      end else if (req_i) begin
        state_d     = BUS_I;
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b0;
        bus_addr_d  = new_i ? mem_i_addr : i_addr_q;
        bus_wdata_d = 32'h0;
        bus_wmask_d = 4'hF;
      end else begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wmask_q <= 4'h0;
      pend_i_q    <= 1'b0;
      pend_d_q    <= 1'b0;
      i_addr_q    <= 32'h0;
      d_addr_q    <= 32'h0;
      d_wdata_q   <= 32'h0;
      d_wmask_q   <= 4'h0;
      d_we_q      <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      pend_i_q    <= pend_i_d;
      pend_d_q    <= pend_d_d;
      i_addr_q    <= i_addr_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wmask_q   <= d_wmask_d;
      d_we_q      <= d_we_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Downstream companion of the rv32i core: merges the core's instruction port (mem_i_*) and data port (mem_d_*) onto one single-port backing bus with a req/ack handshake. It generates the core's rbusy/wbusy freeze signals and holds returned read data stable until the next read on that port completes. At most one bus transaction is outstanding. Data requests win over instruction requests.

## Interface
- No parameters. All addresses and data are 32 bits; masks are 4 bits.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_i_addr  in  32  instruction read address
- mem_i_rstrb  in  1  instruction read strobe (level, held while frozen)
- mem_i_rdata  out  32  last completed instruction read data
- mem_i_rbusy  out  1  instruction read in progress
- mem_d_addr  in  32  data address
- mem_d_wdata  in  32  store data
- mem_d_wmask  in  4  byte-enable for stores
- mem_d_wstrb  in  1  store strobe
- mem_d_rstrb  in  1  load strobe
- mem_d_rdata  out  32  last completed data read
- mem_d_rbusy  out  1  load in progress
- mem_d_wbusy  out  1  store in progress
- bus_req  out  1  transaction request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  transaction address
- bus_wdata  out  32  write data
- bus_wmask  out  4  byte-enable (4'b1111 for reads)
- bus_ack  in  1  one-cycle completion pulse; bus_rdata valid in the same cycle
- bus_rdata  in  32  read data

## Operation
- **Per-port request latch.** A new request is a strobe seen while that port has no request pending.
  - The latch captures addr, plus wdata/wmask/we on the D port, and sets `pend_i` or `pend_d`.
  - On the D port, if wstrb and rstrb are both high, the request is a write; rstrb is ignored.
- **FSM states:** IDLE, BUS_I, BUS_D. State and all bus_* outputs are registered.
  - IDLE: if a D request (pending or new) exists, go to BUS_D. Otherwise, if an I request exists, go to BUS_I. Otherwise stay in IDLE. The bus_* outputs load from the live strobe inputs for a new request, or from the latch for a pending one.
  - BUS_x: hold bus_req and all bus_* outputs constant until bus_ack. On ack:
    - clear pend_x;
    - on a read, write bus_rdata into the hold register of that port (mem_i_rdata or mem_d_rdata);
    - choose the next state with the IDLE rule, except that the completing port's strobe in the ack cycle is never a new request.
- **Busy outputs (combinational):**
  - `mem_i_rbusy = (mem_i_rstrb | pend_i) & ~ack_i`.
  - `mem_d_rbusy` uses the same form with the D read request; `mem_d_wbusy` uses it with the D write request.
  - `ack_x` = bus_ack while in BUS_x.
- **Back-to-back strobes.** A strobe in the cycle after that port's ack cycle is a new request.
- **Reset values:** FSM = IDLE; bus_req = 0; bus_we = 0; bus_addr, bus_wdata, bus_wmask = 0; pend_i = pend_d = 0; mem_i_rdata = mem_d_rdata = 0. All busy outputs are 0 unless a strobe is high in the cycle after reset.
- **Reset mid-transaction:** abandon the transaction and drop bus_req in the next cycle. An ack arriving while in IDLE is ignored.
- bus_ack while bus_req = 0 is ignored.

## Timing
- **Zero-wait bus** (ack in the first bus_req cycle):
  - cycle 0: strobe, busy = 1;
  - cycle 1: bus_req = 1, ack, busy = 0;
  - cycle 2: the rdata output holds the new value and bus_req = 0, or bus_req stays 1 if the other port is queued.
- **N-cycle bus:** busy stays high for N+1 cycles.
- **Simultaneous I and D strobes in cycle 0:**
  - D is issued in cycle 1.
  - I is issued in the cycle after D's ack, with no IDLE bubble.
  - mem_i_rbusy stays high throughout.
- Bus outputs never change while bus_req = 1 and ack = 0.

## Test plan
- **Zero-wait I read:** rst pulse, then mem_i_rstrb = 1 with addr 0x100, and the bus acks in its first cycle with 0x00500093. Required: rbusy high exactly one cycle; bus_addr = 0x100, bus_we = 0; mem_i_rdata = 0x00500093 two cycles after the strobe; a single bus transaction.
- **Delayed D write:** wstrb with addr 0x2004, wdata 0xDEADBEEF, wmask 4'b0010, ack after 3 cycles. Required: wbusy high 4 cycles; bus fields stable throughout; bus_we = 1.
- **Simultaneous I and D:** I at 0x10 and D read at 0x3000, each acked after 1 cycle with 0x11111111 / 0x22222222. Required: D is issued first, then I with no bubble; each rdata output is correct; mem_d_rdata is unchanged by the I read.
- **Hold:** a read completes, then an idle gap of 10 cycles, then a D write. Required: mem_i_rdata and mem_d_rdata are unchanged throughout.
- **Reset mid-transaction:** rst asserted while bus_req is pending. Required: bus_req = 0 next cycle, all outputs at reset values; a late ack is ignored and no transaction is started.
- **Strobe held through ack:** the core keeps rstrb high in the ack cycle. Required: no second transaction; a new strobe one cycle later starts a new one.
